writeback_arbiter: RTL

- Producer side of the register file write port: merges results from two execution sources into the single rd/rd_write/rd_value write port.
- Port A is the single-cycle ALU result. Port B carries long-latency results (load unit, mul/div) and is buffered in a small FIFO.
- Drives a registered write stage that respects the register file's stall qualification, plus a per-register pending-write mask for hazard logic.

---
 rtl/writeback_arbiter_pkg.sv | 23 ++
 rtl/writeback_arbiter_if.sv | 31 +++
 rtl/writeback_fifo.sv | 70 +++++++
 rtl/writeback_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter and its result FIFO.
// The optional busy mask is enabled by defining WRITEBACK_BUSY_EN.
`ifndef XLEN
`define XLEN 32
`endif

package writeback_arbiter_pkg;

   typedef struct packed {
      logic [4:0]       rd;
      logic [`XLEN-1:0] value;
   } wb_entry_t;

   localparam logic [4:0] REG_ZERO      = 5'd0;
   localparam int         WB_FIFO_DEPTH = 2;
   localparam int         WB_PTR_W      = $clog2(WB_FIFO_DEPTH);

   // One-hot register mask; x0 never appears because it is never written.
   function automatic logic [31:0] rd_onehot(input logic [4:0] r);
      return (32'd1 << r) & ~32'd1;
   endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: two result sources in, one register-file write port out.
`ifndef XLEN
`define XLEN 32
`endif

interface writeback_arbiter_if;
   logic             stall;
   logic             a_valid;
   logic             a_ready;
   logic [4:0]       a_rd;
   logic [`XLEN-1:0] a_value;
   logic             b_valid;
   logic             b_ready;
   logic [4:0]       b_rd;
   logic [`XLEN-1:0] b_value;
   logic [4:0]       rd;
   logic             rd_write;
   logic [`XLEN-1:0] rd_value;
   logic [31:0]      busy;
   logic             idle;

   modport master (
      output stall, a_valid, a_rd, a_value, b_valid, b_rd, b_value,
      input  a_ready, b_ready, rd, rd_write, rd_value, busy, idle
   );

   modport slave (
      input  stall, a_valid, a_rd, a_value, b_valid, b_rd, b_value,
      output a_ready, b_ready, rd, rd_write, rd_value, busy, idle
   );
endinterface

// File: rtl/writeback_fifo.sv
// Circular FIFO of pending port-B writebacks; DEPTH must be a power of two so
// the pointers wrap naturally. Per-entry valid/rd vectors feed the busy mask.
module writeback_fifo
   import writeback_arbiter_pkg::*;
#(
   parameter int DEPTH = WB_FIFO_DEPTH
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        push,
   input  wb_entry_t                   din,
   input  logic                        pop,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(DEPTH):0]      count,
   output wb_entry_t                   head,
   output logic [DEPTH-1:0]            entry_valid,
   output logic [DEPTH-1:0][4:0]       entry_rd
);
   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [PTR_W:0]   cnt;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         wptr <= push ? wptr + PTR_W'(1) : wptr;
         rptr <= pop  ? rptr + PTR_W'(1) : rptr;
         case ({push, pop})
            2'b10:   cnt <= cnt + (PTR_W+1)'(1);
            2'b01:   cnt <= cnt - (PTR_W+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Entry storage.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wptr] <= din;
      end else begin
         mem <= mem;
      end
   end

   // An entry is live when its distance from the read pointer is below count.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         entry_valid[i] = ({1'b0, PTR_W'(i) - rptr} < cnt);
         entry_rd[i]    = mem[i].rd;
      end
   end

   assign full  = (cnt == (PTR_W+1)'(DEPTH));
   assign empty = (cnt == '0);
   assign count = cnt;
   assign head  = mem[rptr];

endmodule

// File: rtl/writeback_arbiter.sv
// Merges single-cycle port A and FIFO-buffered port B results into one
// registered register-file write port. Define WRITEBACK_BUSY_EN for the busy mask.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
   input  logic                clock,
   input  logic                reset_n,
   writeback_arbiter_if.slave  bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   wb_entry_t                    out_entry;
   logic                         out_valid;
   logic                         out_fire;
   logic                         loadable;
   logic                         a_load;
   logic                         fifo_push;
   logic                         fifo_pop;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic [CNT_W-1:0]             fifo_count;
   wb_entry_t                    fifo_head;
   wb_entry_t                    b_entry;
   logic [FIFO_DEPTH-1:0]        entry_valid;
   logic [FIFO_DEPTH-1:0][4:0]   entry_rd;

   assign out_fire  = out_valid && !bus.stall;
   assign loadable  = !out_valid || out_fire;
   assign a_load    = bus.a_valid && (bus.a_rd != REG_ZERO) && !fifo_full;
   // A full FIFO wins over A so long-latency results cannot starve.
   assign fifo_pop  = loadable && !fifo_empty && (fifo_full || !a_load);
   assign fifo_push = bus.b_valid && bus.b_ready && (bus.b_rd != REG_ZERO);
   assign b_entry   = '{rd: bus.b_rd, value: bus.b_value};

   assign bus.a_ready = (bus.a_rd == REG_ZERO) || (loadable && !fifo_full);
   assign bus.b_ready = (fifo_count < CNT_W'(FIFO_DEPTH));

   writeback_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock       (clock),
      .reset_n     (reset_n),
      .push        (fifo_push),
      .din         (b_entry),
      .pop         (fifo_pop),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .count       (fifo_count),
      .head        (fifo_head),
      .entry_valid (entry_valid),
      .entry_rd    (entry_rd)
   );

   // Output stage: holds under stall, otherwise reloads from the chosen source.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_entry <= '0;
      end else if (loadable) begin
         if (fifo_pop) begin
            out_valid <= 1'b1;
            out_entry <= fifo_head;
         end else if (a_load) begin
            out_valid <= 1'b1;
            out_entry <= '{rd: bus.a_rd, value: bus.a_value};
         end else begin
            out_valid <= 1'b0;
            out_entry <= out_entry;
         end
      end else begin
         out_valid <= out_valid;
         out_entry <= out_entry;
      end
   end

   assign bus.rd       = out_entry.rd;
   assign bus.rd_value = out_entry.value;
   assign bus.rd_write = out_valid;
   assign bus.idle     = !out_valid && fifo_empty;

`ifdef WRITEBACK_BUSY_EN
   logic [31:0] busy_mask;

   // Pending-write mask over the presented write and every live FIFO entry.
   always_comb begin
      busy_mask = out_valid ? rd_onehot(out_entry.rd) : 32'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (entry_valid[i]) begin
            busy_mask = busy_mask | rd_onehot(entry_rd[i]);
         end else begin
            busy_mask = busy_mask;
         end
      end
   end

   assign bus.busy = busy_mask;
`else
   logic unused_entry_info;
   assign unused_entry_info = ^{entry_valid, entry_rd};
   assign bus.busy          = 32'b0;
`endif

endmodule
